// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU pipeline: data widths, reset defaults and
// the IF/ID pipeline register payload.
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC  = 32'h0000_0000;
  localparam logic [INSTR_W-1:0] DEFAULT_NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [XLEN-1:0]    pc_plus4;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } if_id_t;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: captures a fetched word, holds on stall and
// turns into a bubble on flush or redirect.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   stall,
  input  logic   flush,
  input  logic   redirect,
  input  if_id_t d,
  output if_id_t q
);

  if_id_t r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q.pc       <= '0;
      r_q.pc_plus4 <= '0;
      r_q.instr    <= NOP_INSTR;
      r_q.valid    <= 1'b0;
    end else if (redirect || flush) begin
      // Bubble: the PC fields keep their last value, only payload is squashed.
      r_q.instr <= NOP_INSTR;
      r_q.valid <= 1'b0;
    end else if (!stall) begin
      r_q <= d;
    end
  end

  assign q = r_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: program counter, ROM addressing, next-PC selection,
// misaligned-redirect flag and retired-fetch counter.
module instr_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [XLEN-1:0]    RESET_PC  = DEFAULT_RESET_PC,
  parameter logic [INSTR_W-1:0] NOP_INSTR = DEFAULT_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  output logic [XLEN-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [XLEN-1:0]    if_pc,
  output logic [XLEN-1:0]    if_pc_plus4,
  output logic [INSTR_W-1:0] if_instr,
  output logic               if_valid,
  output logic               misalign,
  output logic [31:0]        fetch_count
);

  localparam logic [XLEN-1:0] RESET_PC_ALIGNED = {RESET_PC[XLEN-1:2], 2'b00};

  logic [XLEN-1:0] r_pc;
  logic            r_misalign;
  logic [31:0]     r_fetch_count;
  logic [XLEN-1:0] w_pc_plus4;
  logic [XLEN-1:0] w_pc_next;
  logic            w_capture;
  if_id_t          w_if_id_d;
  if_id_t          w_if_id_q;

  assign w_pc_plus4 = r_pc + 32'd4;
  assign w_capture  = !redirect_valid && !flush && !stall;

  // Flush alone still advances the PC; only stall or redirect stop it.
  always_comb begin
    w_pc_next = w_pc_plus4;
    if (redirect_valid) begin
      w_pc_next = {redirect_pc[XLEN-1:2], 2'b00};
    end else if (stall) begin
      w_pc_next = r_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc          <= RESET_PC_ALIGNED;
      r_misalign    <= 1'b0;
      r_fetch_count <= '0;
    end else begin
      r_pc       <= w_pc_next;
      r_misalign <= redirect_valid && (redirect_pc[1:0] != 2'b00);
      if (w_capture) begin
        r_fetch_count <= r_fetch_count + 32'd1;
      end
    end
  end

  assign w_if_id_d.pc       = r_pc;
  assign w_if_id_d.pc_plus4 = w_pc_plus4;
  assign w_if_id_d.instr    = imem_rdata;
  assign w_if_id_d.valid    = 1'b1;

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id_reg (
    .clk     (clk),
    .rst     (rst),
    .stall   (stall),
    .flush   (flush),
    .redirect(redirect_valid),
    .d       (w_if_id_d),
    .q       (w_if_id_q)
  );

  assign imem_addr   = {r_pc[XLEN-1:2], 2'b00};
  assign if_pc       = w_if_id_q.pc;
  assign if_pc_plus4 = w_if_id_q.pc_plus4;
  assign if_instr    = w_if_id_q.instr;
  assign if_valid    = w_if_id_q.valid;
  assign misalign    = r_misalign;
  assign fetch_count = r_fetch_count;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: behavioural fetch model compared every cycle,
// plus directed literal checks of the test plan scenarios.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rst_w = 1'b1;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;

  logic [31:0] imem_addr, imem_rdata, if_pc, if_pc_plus4, if_instr, fetch_count;
  logic        if_valid, misalign;
  logic [31:0] w_imem_addr, w_imem_rdata, w_if_pc, w_if_pc_plus4, w_if_instr, w_fetch_count;
  logic        w_if_valid, w_misalign;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [31:0] addr);
    return 32'h1000_0000 + (addr >> 2);
  endfunction

  assign imem_rdata   = rom(imem_addr);
  assign w_imem_rdata = rom(w_imem_addr);

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .if_pc(if_pc),
    .if_pc_plus4(if_pc_plus4), .if_instr(if_instr), .if_valid(if_valid),
    .misalign(misalign), .fetch_count(fetch_count)
  );

  instr_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .NOP_INSTR(32'h0000_0000)) dut_w (
    .clk(clk), .rst(rst_w), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_addr(w_imem_addr), .imem_rdata(w_imem_rdata), .if_pc(w_if_pc),
    .if_pc_plus4(w_if_pc_plus4), .if_instr(w_if_instr), .if_valid(w_if_valid),
    .misalign(w_misalign), .fetch_count(w_fetch_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model of the fetch stage for the main instance.
  logic [31:0] m_pc, m_if_pc, m_if_pc4, m_if_instr, m_cnt;
  logic        m_valid, m_mis;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc <= 32'h0; m_if_pc <= 32'h0; m_if_pc4 <= 32'h0; m_if_instr <= 32'h0;
      m_valid <= 1'b0; m_mis <= 1'b0; m_cnt <= 32'h0;
    end else begin
      m_mis <= redirect_valid && (redirect_pc % 4 != 0);
      if (redirect_valid) begin
        m_pc <= redirect_pc - (redirect_pc % 4);
        m_valid <= 1'b0; m_if_instr <= 32'h0;
      end else if (flush) begin
        m_valid <= 1'b0; m_if_instr <= 32'h0;
        if (!stall) m_pc <= m_pc + 4;
      end else if (!stall) begin
        m_if_pc <= m_pc; m_if_pc4 <= m_pc + 4; m_if_instr <= rom(m_pc);
        m_valid <= 1'b1; m_cnt <= m_cnt + 1; m_pc <= m_pc + 4;
      end
    end
  end

  always @(negedge clk) begin
    chk("mdl_imem_addr", imem_addr, m_pc);
    chk("mdl_if_pc", if_pc, m_if_pc);
    chk("mdl_if_pc_plus4", if_pc_plus4, m_if_pc4);
    chk("mdl_if_instr", if_instr, m_if_instr);
    chk("mdl_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
    chk("mdl_misalign", {31'b0, misalign}, {31'b0, m_mis});
    chk("mdl_fetch_count", fetch_count, m_cnt);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    step(); step();
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_instr", if_instr, 32'h0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    rst = 1'b0;

    // Sequential fetch
    step();
    chk("seq_if_pc0", if_pc, 32'h0);
    chk("seq_instr0", if_instr, 32'h1000_0000);
    chk("seq_valid0", {31'b0, if_valid}, 32'h1);
    step();
    chk("seq_if_pc1", if_pc, 32'h4);
    step();
    chk("seq_if_pc2", if_pc, 32'h8);
    chk("seq_instr2", if_instr, 32'h1000_0002);

    // Stall hold while if_pc = 8
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_if_pc", if_pc, 32'h8);
      chk("stall_instr", if_instr, 32'h1000_0002);
      chk("stall_imem_addr", imem_addr, 32'hC);
    end
    stall = 1'b0;
    step();
    chk("post_stall_if_pc", if_pc, 32'hC);
    chk("post_stall_instr", if_instr, 32'h1000_0003);
    chk("seq_fetch_count", fetch_count, 32'd4);

    // Redirect with stall at pc = 16
    chk("pre_redir_addr", imem_addr, 32'h10);
    redirect_valid = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
    step();
    redirect_valid = 1'b0; stall = 1'b0;
    chk("redir_bubble", {31'b0, if_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'h40);
    chk("redir_misalign", {31'b0, misalign}, 32'h0);
    step();
    chk("redir_if_pc", if_pc, 32'h40);
    chk("redir_instr", if_instr, 32'h1000_0010);
    chk("redir_valid", {31'b0, if_valid}, 32'h1);
    chk("redir_count", fetch_count, 32'd5);

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h42;
    step();
    redirect_valid = 1'b0;
    chk("mis_pulse", {31'b0, misalign}, 32'h1);
    chk("mis_bubble", {31'b0, if_valid}, 32'h0);
    step();
    chk("mis_clear", {31'b0, misalign}, 32'h0);
    chk("mis_if_pc", if_pc, 32'h40);

    // Flush with stall
    flush = 1'b1; stall = 1'b1;
    step();
    flush = 1'b0; stall = 1'b0;
    chk("fs_valid", {31'b0, if_valid}, 32'h0);
    chk("fs_instr", if_instr, 32'h0);
    chk("fs_pc_held", imem_addr, 32'h44);
    chk("fs_if_pc_hold", if_pc, 32'h40);
    chk("fs_count", fetch_count, 32'd6);
    step();
    chk("fs_resume_pc", if_pc, 32'h44);

    // Flush alone advances pc
    flush = 1'b1;
    step();
    flush = 1'b0;
    chk("fl_pc_adv", imem_addr, 32'h4C);
    chk("fl_valid", {31'b0, if_valid}, 32'h0);
    step();
    chk("fl_if_pc", if_pc, 32'h4C);

    // Async reset between edges on the main instance
    #2 rst = 1'b1;
    #1;
    chk("async_if_pc", if_pc, 32'h0);
    chk("async_count", fetch_count, 32'h0);
    chk("async_addr", imem_addr, 32'h0);
    rst = 1'b0;
    step();
    chk("after_async_if_pc", if_pc, 32'h0);

    // Wrap instance with RESET_PC = 0xFFFF_FFFC
    chk("w_rst_addr", w_imem_addr, 32'hFFFF_FFFC);
    rst_w = 1'b0;
    step();
    chk("w_if_pc0", w_if_pc, 32'hFFFF_FFFC);
    chk("w_pc_plus4", w_if_pc_plus4, 32'h0);
    step();
    chk("w_if_pc1", w_if_pc, 32'h0);
    chk("w_instr1", w_if_instr, 32'h1000_0000);
    #2 rst_w = 1'b1;
    #1;
    chk("w_async_if_pc", w_if_pc, 32'h0);
    chk("w_async_pc4", w_if_pc_plus4, 32'h0);
    chk("w_async_instr", w_if_instr, 32'h0);
    chk("w_async_valid", {31'b0, w_if_valid}, 32'h0);
    chk("w_async_mis", {31'b0, w_misalign}, 32'h0);
    chk("w_async_count", w_fetch_count, 32'h0);
    chk("w_async_addr", w_imem_addr, 32'hFFFF_FFFC);
    rst_w = 1'b0;
    step(); step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Fetch stage of the single-issue pipelined CPU, directly upstream of the combinational instruction ROM. Holds the program counter, drives the ROM address each cycle, captures the returned instruction word into the IF/ID pipeline register and forwards it downstream with a valid flag. Handles decode stalls, pipeline flushes and branch/jump redirects, and keeps a fetch counter for performance monitoring.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- NOP_INSTR, 32'h0000_0000: value of `if_instr` on reset and on bubbles.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, asynchronous and active-high.
- stall  in  1  hold the PC and the IF/ID register.
- flush  in  1  squash the IF/ID contents (insert a bubble).
- redirect_valid  in  1  a taken branch or jump is in effect this cycle.
- redirect_pc  in  32  target address for the redirect.
- imem_addr  out  32  byte address to the instruction ROM `A` port.
- imem_rdata  in  32  instruction word from the ROM `RD` port, combinational from `imem_addr`.
- if_pc  out  32  PC of the instruction held in IF/ID.
- if_pc_plus4  out  32  `if_pc + 4`, registered.
- if_instr  out  32  instruction held in IF/ID.
- if_valid  out  1  IF/ID holds a real instruction.
- misalign  out  1  one-cycle pulse: the accepted redirect target had bits [1:0] != 0.
- fetch_count  out  32  number of instructions captured with `if_valid` = 1.

## Operation
- `pc` register. `imem_addr = {pc[31:2], 2'b00}`, combinational. The ROM returns `imem_rdata` in the same cycle.
- Per-edge priority, highest first: rst, redirect_valid, flush, stall, normal.
- **Normal:** `pc <= pc + 4`. IF/ID captures `{pc, pc+4, imem_rdata}`, `if_valid <= 1`, `fetch_count++`.
- **Stall:** `pc`, IF/ID and `fetch_count` all hold.
- **Flush, no redirect:** `if_valid <= 0`, `if_instr <= NOP_INSTR`. `if_pc`/`if_pc_plus4` hold. `pc` advances by 4 unless stall is also high, in which case `pc` holds.
- **Redirect:** overrides both stall and flush.
  - `pc <= {redirect_pc[31:2], 2'b00}`.
  - The wrong-path word fetched this cycle is discarded: `if_valid <= 0`, `if_instr <= NOP_INSTR`. `fetch_count` holds.
  - `misalign <= |redirect_pc[1:0]`.
- `misalign` is 0 on every cycle without a redirect.
- **Arithmetic:** PC increment is modulo 2^32, so 32'hFFFF_FFFC + 4 = 32'h0000_0000 with no flag. `fetch_count` also wraps modulo 2^32.
- **Reset values:**
  - `pc = RESET_PC` (low two bits forced to 0)
  - `if_pc = 0`, `if_pc_plus4 = 0`
  - `if_instr = NOP_INSTR`
  - `if_valid = 0`, `misalign = 0`, `fetch_count = 0`
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). Any pending redirect is lost.

## Timing
- Fetch latency is 1 cycle: the word at `imem_addr` in cycle n appears on `if_instr` in cycle n+1.
- First instruction after reset: `rst` deasserts before edge k. `imem_addr = RESET_PC` during cycle k-1/k. `if_valid = 1` with `if_pc = RESET_PC` after edge k.
- Redirect timing:
  - `redirect_valid` sampled at edge n.
  - `imem_addr = target` in cycle n+1.
  - `if_valid` = 0 in cycle n+1, then `if_pc = target` with `if_valid = 1` in cycle n+2.
  - Branch penalty is exactly one bubble.
- Stall is sampled per edge. Outputs are stable for as long as stall is high, and no instruction is lost or duplicated.
- All outputs except `imem_addr` are registered. `imem_addr` is a direct function of the `pc` register only, with no combinational path from any input.

## Structure
- Shared package `cpu_pkg` holds:
  - `XLEN` = 32 and `INSTR_W` = 32
  - default `RESET_PC` and `NOP_INSTR`
  - a packed `if_id_t` struct: pc, pc_plus4, instr, valid
- One sub-module, `if_id_reg`. It takes the `if_id_t` input, the stall/flush/redirect controls and the async reset, and implements the capture/hold/bubble rules above. The next-PC mux, `misalign` and `fetch_count` stay in `instr_fetch_unit`.

## Test plan
- **Reset and sequential fetch:** RESET_PC=0, ROM word[i] = 32'h1000_0000+i, release rst, no stall. Required: `if_pc` 0, 4, 8, 12 on successive cycles, `if_instr` 0x1000_0000..0x1000_0003, `fetch_count` = 4.
- **Stall hold:** stall for 3 cycles while `if_pc` = 8. Required: `if_pc` = 8, `if_instr` = 0x1000_0002 and `imem_addr` = 12 all held. After release, `if_pc` = 12 next cycle.
- **Redirect with stall:** at `pc` = 16 assert `redirect_valid` with target 0x40 and stall=1 in the same cycle. Required: one bubble (`if_valid` = 0), then `if_pc` = 0x40, `if_instr` = ROM[16], `misalign` = 0.
- **Misaligned redirect:** target 0x42. Required: `misalign` pulses for exactly 1 cycle, then `if_pc` = 0x40.
- **Flush with stall:** assert flush and stall together. Required: `if_valid` = 0, `if_instr` = 0, `pc` held, `fetch_count` unchanged.
- **Wrap and async reset:** RESET_PC = 32'hFFFF_FFFC. Required: `if_pc` goes 0xFFFF_FFFC then 0x0. Pulse rst between clock edges: all outputs return to their reset values before the next edge.
